// File: rtl/l2_response_receiver_pkg.sv
// Shared types for the core-side L2 response receiver: packet layout, cache
// line types and miss-table sizing.
package l2_response_receiver_pkg;

    localparam int NUM_MISS_ENTRIES       = 8;
    localparam int MISS_ID_WIDTH          = $clog2(NUM_MISS_ENTRIES);
    localparam int THREADS_PER_CORE       = 4;
    localparam int CORE_ID_WIDTH          = 4;
    localparam int CACHE_LINE_BYTES       = 64;
    localparam int CACHE_LINE_BITS        = CACHE_LINE_BYTES * 8;
    localparam int CACHE_LINE_INDEX_WIDTH = 32 - $clog2(CACHE_LINE_BYTES);

    typedef logic [MISS_ID_WIDTH-1:0]          miss_entry_idx_t;
    typedef logic [MISS_ID_WIDTH:0]            miss_count_t;
    typedef logic [THREADS_PER_CORE-1:0]       thread_bitmap_t;
    typedef logic [CORE_ID_WIDTH-1:0]          core_id_t;
    typedef logic [CACHE_LINE_BITS-1:0]        cache_line_data_t;
    typedef logic [CACHE_LINE_INDEX_WIDTH-1:0] cache_line_index_t;

    typedef enum logic {
        CT_ICACHE = 1'b0,
        CT_DCACHE = 1'b1
    } cache_type_t;

    typedef enum logic [2:0] {
        L2RSP_LOAD_ACK        = 3'd0,
        L2RSP_STORE_ACK       = 3'd1,
        L2RSP_FLUSH_ACK       = 3'd2,
        L2RSP_IINVALIDATE_ACK = 3'd3,
        L2RSP_DINVALIDATE_ACK = 3'd4
    } l2rsp_packet_type_t;

    typedef struct packed {
        logic               status;
        core_id_t           core;
        miss_entry_idx_t    id;
        l2rsp_packet_type_t packet_type;
        cache_type_t        cache_type;
        cache_line_data_t   data;
        cache_line_index_t  address;
    } l2rsp_packet_t;

    // Invalidate acks are broadcast and must be honoured by every core.
    function automatic logic is_broadcast(input l2rsp_packet_type_t t);
        return (t == L2RSP_IINVALIDATE_ACK) || (t == L2RSP_DINVALIDATE_ACK);
    endfunction

endpackage

// File: rtl/l2_response_receiver_if.sv
// Response-bus, miss-allocation and L1-side result signals of one core's
// L2 response receiver.
interface l2_response_receiver_if;
    import l2_response_receiver_pkg::*;

    logic              l2_response_valid;
    l2rsp_packet_t     l2_response;
    logic              miss_alloc_en;
    miss_entry_idx_t   miss_alloc_id;
    thread_bitmap_t    miss_alloc_threads;

    logic              l2rr_fill_en;
    cache_type_t       l2rr_fill_cache_type;
    cache_line_index_t l2rr_fill_address;
    cache_line_data_t  l2rr_fill_data;
    logic              l2rr_inval_en;
    cache_type_t       l2rr_inval_cache_type;
    cache_line_index_t l2rr_inval_address;
    logic              l2rr_store_ack_en;
    logic              l2rr_store_ack_status;
    miss_entry_idx_t   l2rr_store_ack_id;
    thread_bitmap_t    l2rr_wake_bitmap;
    miss_count_t       l2rr_pending_count;

    modport master (
        output l2_response_valid, l2_response, miss_alloc_en, miss_alloc_id, miss_alloc_threads,
        input  l2rr_fill_en, l2rr_fill_cache_type, l2rr_fill_address, l2rr_fill_data,
               l2rr_inval_en, l2rr_inval_cache_type, l2rr_inval_address,
               l2rr_store_ack_en, l2rr_store_ack_status, l2rr_store_ack_id,
               l2rr_wake_bitmap, l2rr_pending_count
    );

    modport slave (
        input  l2_response_valid, l2_response, miss_alloc_en, miss_alloc_id, miss_alloc_threads,
        output l2rr_fill_en, l2rr_fill_cache_type, l2rr_fill_address, l2rr_fill_data,
               l2rr_inval_en, l2rr_inval_cache_type, l2rr_inval_address,
               l2rr_store_ack_en, l2rr_store_ack_status, l2rr_store_ack_id,
               l2rr_wake_bitmap, l2rr_pending_count
    );

endinterface

// File: rtl/l2_response_receiver_miss_table.sv
// Pending-miss table: per-id valid bit and waiting-thread mask, with a
// combinational read port, one alloc/merge port, one free port and an occupancy count.
module l2rr_miss_table
    import l2_response_receiver_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_alloc_en,
    input  miss_entry_idx_t i_alloc_id,
    input  thread_bitmap_t  i_alloc_threads,
    input  logic            i_free_en,
    input  miss_entry_idx_t i_free_id,
    input  miss_entry_idx_t i_rd_id,
    output logic            o_rd_valid,
    output thread_bitmap_t  o_rd_mask,
    output miss_count_t     o_pending_count
);

    logic [NUM_MISS_ENTRIES-1:0] r_valid;
    thread_bitmap_t              r_mask [NUM_MISS_ENTRIES];
    miss_count_t                 r_pending;
    logic                        w_same_slot;
    logic                        w_inc;
    logic                        w_dec;

    assign o_rd_valid      = r_valid[i_rd_id];
    assign o_rd_mask       = r_mask[i_rd_id];
    assign o_pending_count = r_pending;

    // A slot freed and re-allocated in one cycle counts as a fresh allocation.
    assign w_same_slot = i_alloc_en && i_free_en && (i_alloc_id == i_free_id);
    assign w_inc       = i_alloc_en && (!r_valid[i_alloc_id] || w_same_slot);
    assign w_dec       = i_free_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_pending <= '0;
            for (int i = 0; i < NUM_MISS_ENTRIES; i++) r_mask[i] <= '0;
        end else begin
            if (i_free_en) begin
                r_valid[i_free_id] <= 1'b0;
                r_mask[i_free_id]  <= '0;
            end
            if (i_alloc_en) begin
                r_valid[i_alloc_id] <= 1'b1;
                r_mask[i_alloc_id]  <= (r_valid[i_alloc_id] && !w_same_slot) ?
                                       (r_mask[i_alloc_id] | i_alloc_threads) : i_alloc_threads;
            end
            if (w_inc && !w_dec)      r_pending <= r_pending + miss_count_t'(1);
            else if (w_dec && !w_inc) r_pending <= r_pending - miss_count_t'(1);
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_inc && !w_dec && r_pending == miss_count_t'(NUM_MISS_ENTRIES)))
        else $error("miss table pending count overflow");
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_dec && !w_inc && r_pending == '0))
        else $error("miss table pending count underflow");
`endif

endmodule

// File: rtl/l2_response_receiver.sv
// Core-side L2 response receiver: filters broadcast/unicast packets, looks up
// the pending miss in stage 1 and issues fill/inval/store-ack/wake in stage 2.
module l2_response_receiver
    import l2_response_receiver_pkg::*;
#(
    parameter core_id_t CORE_ID = '0
) (
    input logic                   clk,
    input logic                   reset,
    l2_response_receiver_if.slave bus
);

    logic              w_accept;
    logic              r_s1_valid;
    l2rsp_packet_t     r_s1_pkt;
    logic              w_s1_load, w_s1_store, w_s1_flush, w_s1_iinv, w_s1_dinv;
    logic              w_rd_valid;
    thread_bitmap_t    w_rd_mask;
    logic              w_free_en;

    logic              r_fill_en;
    cache_type_t       r_fill_ct;
    cache_line_index_t r_fill_addr;
    cache_line_data_t  r_fill_data;
    logic              r_inval_en;
    cache_type_t       r_inval_ct;
    cache_line_index_t r_inval_addr;
    logic              r_st_en;
    logic              r_st_status;
    miss_entry_idx_t   r_st_id;
    thread_bitmap_t    r_wake;

    assign w_accept = bus.l2_response_valid &&
                      ((bus.l2_response.core == CORE_ID) || is_broadcast(bus.l2_response.packet_type));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_pkt   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) r_s1_pkt <= bus.l2_response;
        end
    end

    assign w_s1_load  = r_s1_valid && (r_s1_pkt.packet_type == L2RSP_LOAD_ACK);
    assign w_s1_store = r_s1_valid && (r_s1_pkt.packet_type == L2RSP_STORE_ACK);
    assign w_s1_flush = r_s1_valid && (r_s1_pkt.packet_type == L2RSP_FLUSH_ACK);
    assign w_s1_iinv  = r_s1_valid && (r_s1_pkt.packet_type == L2RSP_IINVALIDATE_ACK);
    assign w_s1_dinv  = r_s1_valid && (r_s1_pkt.packet_type == L2RSP_DINVALIDATE_ACK);
    // Only a live entry is freed, so a stray LOAD_ACK cannot drag the count negative.
    assign w_free_en  = w_s1_load && w_rd_valid;

    l2rr_miss_table u_miss_table (
        .clk             (clk),
        .rst             (reset),
        .i_alloc_en      (bus.miss_alloc_en),
        .i_alloc_id      (bus.miss_alloc_id),
        .i_alloc_threads (bus.miss_alloc_threads),
        .i_free_en       (w_free_en),
        .i_free_id       (r_s1_pkt.id),
        .i_rd_id         (r_s1_pkt.id),
        .o_rd_valid      (w_rd_valid),
        .o_rd_mask       (w_rd_mask),
        .o_pending_count (bus.l2rr_pending_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_en    <= 1'b0;
            r_fill_ct    <= CT_ICACHE;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
            r_inval_en   <= 1'b0;
            r_inval_ct   <= CT_ICACHE;
            r_inval_addr <= '0;
            r_st_en      <= 1'b0;
            r_st_status  <= 1'b0;
            r_st_id      <= '0;
            r_wake       <= '0;
        end else begin
            r_fill_en  <= w_s1_load;
            r_inval_en <= w_s1_iinv || w_s1_dinv;
            r_st_en    <= w_s1_store || w_s1_flush;
            r_wake     <= w_free_en ? w_rd_mask : '0;
            if (w_s1_load) begin
                r_fill_ct   <= r_s1_pkt.cache_type;
                r_fill_addr <= r_s1_pkt.address;
                r_fill_data <= r_s1_pkt.data;
            end
            if (w_s1_iinv || w_s1_dinv) begin
                r_inval_ct   <= w_s1_iinv ? CT_ICACHE : CT_DCACHE;
                r_inval_addr <= r_s1_pkt.address;
            end
            if (w_s1_store || w_s1_flush) begin
                r_st_status <= w_s1_flush ? 1'b1 : r_s1_pkt.status;
                r_st_id     <= r_s1_pkt.id;
            end
        end
    end

    assign bus.l2rr_fill_en          = r_fill_en;
    assign bus.l2rr_fill_cache_type  = r_fill_ct;
    assign bus.l2rr_fill_address     = r_fill_addr;
    assign bus.l2rr_fill_data        = r_fill_data;
    assign bus.l2rr_inval_en         = r_inval_en;
    assign bus.l2rr_inval_cache_type = r_inval_ct;
    assign bus.l2rr_inval_address    = r_inval_addr;
    assign bus.l2rr_store_ack_en     = r_st_en;
    assign bus.l2rr_store_ack_status = r_st_status;
    assign bus.l2rr_store_ack_id     = r_st_id;
    assign bus.l2rr_wake_bitmap      = r_wake;

`ifndef SYNTHESIS
    a_load_hits_live_entry: assert property (@(posedge clk) disable iff (reset)
        !(w_s1_load && !w_rd_valid))
        else $warning("LOAD_ACK for idle miss entry %0d, fill issued without wake", r_s1_pkt.id);
`endif

endmodule

// File: doc/l2_response_receiver.md
Name: l2_response_receiver

Overview:
- Core-side terminus of the L2 response bus.
- Sits in each core and accepts l2_response_valid/l2_response packets broadcast by the L2 update stage.
- Tracks outstanding L1 miss requests by id, then issues L1 fill writes, invalidates, store-queue acks and thread wake-ups through a two-stage pipeline.

Parameters:
- CORE_ID, 0: core index; unicast packets are consumed only when l2_response.core equals this value.
- NUM_MISS_ENTRIES, 8: pending-miss table depth; the id field indexes it directly (width clog2).
- THREADS_PER_CORE, 4: width of the wake bitmaps.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- l2_response_valid  in  1  response packet valid
- l2_response  in  l2rsp_packet_t  status, core, id, packet_type, cache_type, data, address
- miss_alloc_en  in  1  L1 miss issued to L2 this cycle
- miss_alloc_id  in  clog2(NUM_MISS_ENTRIES)  table slot for the miss
- miss_alloc_threads  in  THREADS_PER_CORE  threads waiting on the miss
- l2rr_fill_en  out  1  write one line into L1
- l2rr_fill_cache_type  out  cache_type_t  icache or dcache target
- l2rr_fill_address  out  cache_line_index_t  line address
- l2rr_fill_data  out  cache_line_data_t  line data
- l2rr_inval_en  out  1  invalidate L1 line
- l2rr_inval_cache_type  out  cache_type_t  icache or dcache target
- l2rr_inval_address  out  cache_line_index_t  line to invalidate
- l2rr_store_ack_en  out  1  store or flush completion to store queue
- l2rr_store_ack_status  out  1  status bit (sync store success)
- l2rr_store_ack_id  out  clog2(NUM_MISS_ENTRIES)  completing id
- l2rr_wake_bitmap  out  THREADS_PER_CORE  threads to resume
- l2rr_pending_count  out  clog2(NUM_MISS_ENTRIES)+1  occupied table slots

Behaviour:
- Reset: all outputs 0, all table entries invalid, both pipeline valids 0. Reset mid-pipeline discards in-flight packets, with no fill and no wake.
- Stage 1 (registered, cycle N+1): capture the packet if l2_response_valid and either condition holds:
  - core == CORE_ID, or
  - packet_type is L2RSP_DINVALIDATE_ACK or L2RSP_IINVALIDATE_ACK. These are broadcast and accepted by every core.
- Stage 1 also reads table[id] (valid, thread mask).
- Stage 2 (registered outputs, cycle N+2); all strobes are single-cycle pulses.
  - LOAD_ACK: fill_en=1, fill outputs from the packet, wake_bitmap = table mask. The entry is freed at the stage-1→2 edge.
  - LOAD_ACK to an invalid entry: fill still issued, wake_bitmap=0. Flagged by simulation assertion.
  - STORE_ACK: store_ack_en=1, status as received, id passed through. No fill; no table change.
  - FLUSH_ACK: store_ack_en=1, status=1.
  - IINVALIDATE_ACK / DINVALIDATE_ACK: inval_en=1, cache_type = icache / dcache respectively, address from packet.
- Allocation:
  - miss_alloc_en with a valid entry ORs miss_alloc_threads into that entry's mask (merge).
  - miss_alloc_en with an invalid entry sets valid and loads the mask.
- Alloc and free of the same id in the same cycle: the entry ends valid with mask = miss_alloc_threads only. The wake output carries the old mask.
- pending_count: +1 on allocation into an invalid slot, -1 on free, unchanged when both occur; saturates at neither end. Over/underflow is a simulation assertion.
- Back-to-back responses: one packet is accepted per cycle with no stall; L2 cannot be back-pressured.
- Two LOAD_ACKs to the same id in consecutive cycles: the second sees the freed entry and wakes nothing.

Decomposition:
- Shared defines package:
  - l2rsp_packet_t, l2rsp_packet_type_t, cache_type_t, cache_line_data_t, cache_line_index_t
  - THREADS_PER_CORE and a new miss_entry_idx_t
- One sub-module: l2rr_miss_table. It holds the valid/mask storage, merge/free logic and pending counter, with a combinational read port and one write/free port.

Test Plan:
- Allocate id 3 with threads 0010; send LOAD_ACK core=CORE_ID id=3 dcache addr 0x1234 → 2 cycles later: fill_en=1, address 0x1234, data equal, wake=0010; pending_count 1→0.
- Allocate id 5 with 0001, then id 5 with 0100 → a LOAD_ACK for id 5 wakes 0101.
- STORE_ACK core=CORE_ID+1 → no output. DINVALIDATE_ACK with core=CORE_ID+1, addr 0x40 → inval_en=1, dcache, 0x40.
- STORE_ACK id=2 status=0 → store_ack_en=1, status 0, id 2, wake=0.
- Same-cycle free and realloc of id 1 (old mask 1000, new mask 0011) → wake=1000, entry remains valid with 0011, count unchanged.
- Assert reset during stage 2 of a LOAD_ACK → no fill, table empty, count 0 after reset.
